// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle of the loadable BCD countdown timer.
// The bench drives through master; the timer sits on slave.
interface bcd_countdown_timer_if #(
    parameter int WL = 4,
    parameter int ND = 4
);
    logic            iEN;
    logic            iLOAD;
    logic [ND*WL-1:0] iLDVAL;
    logic            iSTART;
    logic            iSTOP;
    logic [ND*WL-1:0] oCNT;
    logic            oBRW;
    logic            oDONE;
    logic            oBUSY;

    modport master (
        output iEN, iLOAD, iLDVAL, iSTART, iSTOP,
        input  oCNT, oBRW, oDONE, oBUSY
    );

    modport slave (
        input  iEN, iLOAD, iLDVAL, iSTART, iSTOP,
        output oCNT, oBRW, oDONE, oBUSY
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit modulo-MV down counter with a borrow chain and an IDLE/RUN/DONE
// control FSM. Optional auto-reload keeps the timer running after each expiry.
module bcd_countdown_timer #(
    parameter int WL          = 4,
    parameter int MV          = 10,
    parameter int ND          = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                  iCLK,
    input  logic                  iRSTn,
    bcd_countdown_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WL-1:0] DIGIT_MAX = WL'(MV - 1);

    state_t            state;
    state_t            state_next;
    logic [ND*WL-1:0]  cnt;
    logic [ND*WL-1:0]  cnt_next;
    logic [ND*WL-1:0]  rld;
    logic [ND*WL-1:0]  rld_next;
    logic [ND*WL-1:0]  ld_clamped;
    logic [ND*WL-1:0]  cnt_dec;
    logic              borrow;
    logic              cnt_zero;
    logic              terminal;
    logic              done_q;

    always_comb begin
        ld_clamped = bus.iLDVAL;
        for (int k = 0; k < ND; k++) begin
            if (int'(bus.iLDVAL[k*WL +: WL]) >= MV) begin
                ld_clamped[k*WL +: WL] = DIGIT_MAX;
            end
        end
    end

    // Ripple borrow: a zero digit wraps to MV-1 and passes the borrow upward.
    always_comb begin
        cnt_dec = cnt;
        borrow  = 1'b1;
        for (int k = 0; k < ND; k++) begin
            if (borrow) begin
                if (cnt[k*WL +: WL] == '0) begin
                    cnt_dec[k*WL +: WL] = DIGIT_MAX;
                end else begin
                    cnt_dec[k*WL +: WL] = cnt[k*WL +: WL] - WL'(1);
                    borrow              = 1'b0;
                end
            end
        end
    end

    assign cnt_zero = (cnt == '0);
    assign terminal = (state == RUN) && bus.iEN && cnt_zero && !bus.iLOAD && !bus.iSTOP;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rld_next   = rld;
        if (bus.iLOAD) begin
            cnt_next   = ld_clamped;
            rld_next   = ld_clamped;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.iSTOP && bus.iSTART) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (bus.iSTOP) begin
                        state_next = IDLE;
                    end else if (bus.iEN) begin
                        if (!cnt_zero) begin
                            cnt_next = cnt_dec;
                        end else if (AUTO_RELOAD != 0) begin
                            cnt_next = rld;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.iSTOP && bus.iSTART) begin
                        cnt_next   = rld;
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state  <= IDLE;
            cnt    <= '0;
            rld    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            rld    <= rld_next;
            done_q <= terminal;
        end
    end

    assign bus.oCNT  = cnt;
    assign bus.oBRW  = terminal;
    assign bus.oDONE = done_q;
    assign bus.oBUSY = (state == RUN);
endmodule
